// File: rtl/stf_preamble_seq.sv
`default_nettype none
// ============================================================================
//  Module   : stf_preamble_seq
//  Purpose  : Walks the external 16-entry STF ROM NUM_REP times and streams
//             the legacy short preamble as packed I/Q words over a
//             valid/ready interface. One preamble per start pulse; abort
//             cancels a preamble in flight.
//  Options  : STF_WINDOW_EN - when defined, sample 0 of each preamble has
//             I and Q halved (arithmetic shift) to form the window edge.
//  Revision : 1.0 - initial release
// ============================================================================
module stf_preamble_seq #(
    parameter int NUM_REP = 10
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic [3:0]  rom_addr,
    input  logic [31:0] rom_dout,
    output logic [31:0] sample_out,
    output logic        sample_valid,
    output logic        sample_last,
    input  logic        sample_ready
);

    localparam logic [0:0] c_IDLE     = 1'b0;
    localparam logic [0:0] c_RUN      = 1'b1;
    localparam logic [3:0] c_NUM_REP  = 4'(NUM_REP);
    localparam logic [3:0] c_LAST_REP = 4'(NUM_REP - 1);

    logic [0:0]  state_q,  state_d;
    logic [3:0]  idx_q,    idx_d;
    logic [3:0]  rep_q,    rep_d;
    logic [31:0] sample_q, sample_d;
    logic        valid_q,  valid_d;
    logic        last_q,   last_d;
    logic        done_q,   done_d;

    logic        w_remaining;
    logic        w_handshake;
    logic        w_final_hs;
    logic        w_load;
    logic [31:0] w_sample_in;

    // rep counts completed ROM passes; once it reaches NUM_REP every
    // sample of the preamble has been loaded into the output register.
    assign w_remaining = (rep_q < c_NUM_REP);
    assign w_handshake = valid_q && sample_ready;
    assign w_final_hs  = w_handshake && last_q;
    assign w_load      = (state_q == c_RUN) && !abort && w_remaining
                         && (!valid_q || sample_ready);

`ifdef STF_WINDOW_EN
    // Sample 0 only: halve I and Q with sign extension (window edge).
    assign w_sample_in = (rep_q == 4'd0 && idx_q == 4'd0)
                         ? {rom_dout[31], rom_dout[31:17], rom_dout[15], rom_dout[15:1]}
                         : rom_dout;
`else
    assign w_sample_in = rom_dout;
`endif

    // State register and all datapath flops, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= c_IDLE;
            idx_q    <= 4'd0;
            rep_q    <= 4'd0;
            sample_q <= 32'd0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            rep_q    <= rep_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            done_q   <= done_d;
        end
    end

    // Next-state logic: abort always wins, which also masks a same-cycle start.
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE:  if (start && !abort) state_d = c_RUN;
            c_RUN:   if (abort || w_final_hs) state_d = c_IDLE;
            default: state_d = c_IDLE;
        endcase
    end

    // Datapath: counters, output register load/hold, done pulse generation.
    always_comb begin
        idx_d    = idx_q;
        rep_d    = rep_q;
        sample_d = sample_q;
        valid_d  = valid_q;
        last_d   = last_q;
        done_d   = 1'b0;
        if (state_q == c_IDLE) begin
            idx_d   = 4'd0;
            rep_d   = 4'd0;
            valid_d = 1'b0;
            last_d  = 1'b0;
        end else if (abort) begin
            // sample_out keeps its last value; it is meaningless without valid.
            idx_d   = 4'd0;
            rep_d   = 4'd0;
            valid_d = 1'b0;
            last_d  = 1'b0;
        end else if (w_load) begin
            sample_d = w_sample_in;
            valid_d  = 1'b1;
            last_d   = (rep_q == c_LAST_REP) && (idx_q == 4'd15);
            idx_d    = idx_q + 4'd1;
            if (idx_q == 4'd15) begin
                rep_d = rep_q + 4'd1;
            end
        end else if (w_handshake) begin
            // Only reachable for the final sample: nothing left to load.
            valid_d = 1'b0;
            last_d  = 1'b0;
            if (w_final_hs) begin
                done_d = 1'b1;
                idx_d  = 4'd0;
                rep_d  = 4'd0;
            end
        end
    end

    // Output decode: everything is a straight flop except busy.
    always_comb begin
        busy = (state_q == c_RUN);
    end

    assign done         = done_q;
    assign rom_addr     = idx_q;
    assign sample_out   = sample_q;
    assign sample_valid = valid_q;
    assign sample_last  = last_q;

endmodule
`default_nettype wire

// File: doc/stf_preamble_seq.md
# stf_preamble_seq

Sequencer that drives the 16-entry short-training-field ROM to produce the complete 802.11 legacy short preamble. On a start pulse it emits NUM_REP back-to-back periods of the 16-sample STF, 160 samples by default, as packed I/Q words on a valid/ready stream. It sits in the OFDM TX chain between the frame controller, which issues start, and the sample mux ahead of the DAC interface.

## Interface
Parameters:
- NUM_REP, 10, number of 16-sample STF periods per preamble; legal range 1..15.

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset; synchronous, active-low.
- start  in  1  single-cycle request to emit one preamble; honoured only in IDLE.
- abort  in  1  single-cycle cancel; returns the block to IDLE.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse after the last sample handshake.
- rom_addr  out  4  address to the STF ROM, which is combinational.
- rom_dout  in  32  ROM data: I in [31:16], Q in [15:0], both signed 16-bit.
- sample_out  out  32  registered I/Q sample.
- sample_valid  out  1  sample_out is valid.
- sample_last  out  1  marks sample NUM_REP*16-1.
- sample_ready  in  1  downstream accepts the sample when sample_valid && sample_ready.

## Operation
- States:
  - IDLE: emits nothing. start → RUN.
  - RUN: emits samples. Last sample accepted → IDLE with a done pulse. abort → IDLE.
- Counters:
  - idx, 4-bit, wraps 15→0.
  - rep, 4-bit.
  - rom_addr = idx at all times.
  - Sample n = rep*16+idx.
- Load rule in RUN: the output register loads when (!sample_valid || sample_ready) and samples remain to be issued.
  - On load: sample_out ← rom_dout, sample_valid ← 1, and sample_last ← (rep==NUM_REP-1 && idx==15).
  - After a load, idx advances; when idx wraps, rep increments.
- After the last sample is loaded, no further loads occur. When the last sample is handshaken: sample_valid ← 0, sample_last ← 0, done ← 1, state → IDLE.
- Handshake rules:
  - With sample_valid=1 and sample_ready=0, sample_out and sample_last hold stable.
  - sample_valid never drops without a handshake, except on abort or reset.
- Boundary cases:
  - start while in RUN: ignored.
  - abort in RUN: sample_valid, sample_last, idx and rep clear on the next edge; no done pulse.
  - abort in IDLE: no effect.
  - start and abort in the same cycle: abort has priority, so start is ignored in any state.
  - start in the cycle done is high: accepted, because the block is already in IDLE.
- Reset values: rom_addr=0, sample_out=0, sample_valid=0, sample_last=0, busy=0, done=0, state=IDLE, idx=0, rep=0.

## Timing
- start is sampled at edge E. busy=1 from E. Sample 0 is valid in the cycle after E+1, so latency is 2 edges.
- With sample_ready held high, one sample is issued per cycle and the preamble occupies exactly NUM_REP*16 consecutive valid cycles.
- The final handshake occurs at edge F. After F: done=1 and busy=0 for exactly one cycle.
- sample_out is taken directly from a register; there is no combinational path from sample_ready to sample_out.

## Configuration
- STF_WINDOW_EN:
  - Defined: sample 0 of each preamble (n==0 only) has I and Q each arithmetically shifted right by 1. This is the half-amplitude window edge; 0x02f2_02f2 becomes 0x0179_0179. All other samples pass unmodified.
  - Undefined: every sample equals rom_dout unchanged.

## Test plan
- Basic run, NUM_REP=10, sample_ready=1, start pulse:
  - 160 contiguous valid cycles.
  - Sample 0 = 0x02f2_02f2 (0x0179_0179 with STF_WINDOW_EN); sample 17 = 0x03d9_0198; sample 159 = 0x0198_03d9 with sample_last=1.
  - done high for one cycle immediately after; busy low from that cycle.
- Backpressure:
  - Drive sample_ready low for 5 cycles at sample 30: sample_out holds 0x0000_042a and sample_valid stays 1.
  - The full 160-sample sequence completes with no loss or duplication.
  - Random 50% sample_ready toggling yields the identical 160-word sequence.
- start pulsed at sample 50 during RUN: ignored; exactly 160 samples, one done.
- abort at sample 70: sample_valid=0 next cycle, no done, busy=0. A following start emits a fresh preamble from sample 0.
- rstn low at sample 90 for one cycle: all outputs at reset values next cycle; no done.
- start in the done cycle: second preamble begins; sample_valid=1 two edges later with sample 0. No gap or overlap beyond the specified latency.
